// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID register.
// Define IF_ALIGN_CHECK_EN to halt on a misaligned redirect instead of masking it.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0064,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] pc_plus4;
    logic        bubble;
    logic        capture;

    assign imem_pc  = pc;
    assign pc_plus4 = pc + 32'd4;

`ifdef IF_ALIGN_CHECK_EN
    logic fault_q;
    logic fault_set;
    logic misaligned;

    assign misaligned  = redirect_target[1:0] != 2'b00;
    assign fetch_fault = fault_q;
`else
    logic unused_tgt_lsb;

    assign unused_tgt_lsb = ^redirect_target[1:0];
    assign fetch_fault    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        bubble  = 1'b0;
        capture = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        fault_set = 1'b0;
`endif
        case (state)
            BOOT: begin
                bubble  = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
                    if (misaligned) begin
                        fault_set = 1'b1;
                        state_n   = HALT;
                    end else begin
                        pc_n = redirect_target;
                    end
`else
                    pc_n = {redirect_target[31:2], 2'b00};
`endif
                end else if (stall) begin
                    bubble = flush;
                end else begin
                    pc_n    = pc_plus4;
                    bubble  = flush;
                    capture = !flush;
                end
            end
            HALT: begin
                bubble = 1'b1;
            end
            default: begin
                bubble  = 1'b1;
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            ifid_inst   <= NOP_INST;
            ifid_pc4    <= 32'd0;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (bubble) begin
                ifid_inst  <= NOP_INST;
                ifid_pc4   <= 32'd0;
                ifid_valid <= 1'b0;
            end else if (capture) begin
                ifid_inst   <= imem_inst;
                ifid_pc4    <= pc_plus4;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed cycles push expectations,
// a monitor pops and compares after each edge or on an async-reset sample.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    logic [31:0] mem [64];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        v;
        logic        f;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;
    event samp;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_pc         (imem_pc),
        .imem_inst       (imem_inst),
        .ifid_inst       (ifid_inst),
        .ifid_pc4        (ifid_pc4),
        .ifid_valid      (ifid_valid),
        .fetch_count     (fetch_count),
        .fetch_fault     (fetch_fault)
    );

    assign imem_inst = mem[imem_pc[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int idx);
        return mem[idx];
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk or samp);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk32("imem_pc", imem_pc, e.pc);
            chk32("ifid_inst", ifid_inst, e.inst);
            chk32("ifid_pc4", ifid_pc4, e.pc4);
            chk32("fetch_count", fetch_count, e.cnt);
            chk32("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
            chk32("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.f});
        end
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] pc4, input logic v,
                                input logic [31:0] cnt, input logic f);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.pc4  = pc4;
        e.v    = v;
        e.cnt  = cnt;
        e.f    = f;
        return e;
    endfunction

    // Called at a negedge: drive, predict, run one edge, return at next negedge.
    task automatic cyc(input logic st, input logic fl, input logic rv,
                       input logic [31:0] tgt, input exp_t e);
        stall           = st;
        flush           = fl;
        redirect_valid  = rv;
        redirect_target = tgt;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        q.push_back(mk(32'h64, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0));
        ->samp;
        #2;
    endtask

    initial begin
        exp_t r;
        bit   al;
        checks = 0;
        errors = 0;
`ifdef IF_ALIGN_CHECK_EN
        al = 1'b1;
`else
        al = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 32'h1300_0013 + (i << 7);
        mem[25] = 32'h0022_1820;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;

        @(negedge clk);
        reset_now();
        @(negedge clk);
        rst = 1'b0;

        cyc(0, 0, 0, 0, mk(32'h64, 32'h0, 32'h0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(32'h68, 32'h0022_1820, 32'h68, 1, 1, 0));
        cyc(0, 0, 0, 0, mk(32'h6C, w(26), 32'h6C, 1, 2, 0));
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, 0, mk(32'h6C, w(26), 32'h6C, 1, 2, 0));
        cyc(0, 0, 0, 0, mk(32'h70, w(27), 32'h70, 1, 3, 0));
        cyc(0, 1, 0, 0, mk(32'h74, 32'h0, 32'h0, 0, 3, 0));
        cyc(0, 0, 0, 0, mk(32'h78, w(29), 32'h78, 1, 4, 0));
        cyc(1, 0, 1, 32'h64, mk(32'h64, 32'h0, 32'h0, 0, 4, 0));
        cyc(0, 0, 0, 0, mk(32'h68, 32'h0022_1820, 32'h68, 1, 5, 0));
        cyc(1, 1, 0, 0, mk(32'h68, 32'h0, 32'h0, 0, 5, 0));
        cyc(0, 0, 0, 0, mk(32'h6C, w(26), 32'h6C, 1, 6, 0));
        cyc(0, 0, 1, 32'hFFFF_FFFC, mk(32'hFFFF_FFFC, 32'h0, 32'h0, 0, 6, 0));
        cyc(0, 0, 0, 0, mk(32'h0, w(63), 32'h0, 1, 7, 0));
        cyc(0, 0, 0, 0, mk(32'h4, w(0), 32'h4, 1, 8, 0));
        cyc(0, 1, 1, 32'h40, mk(32'h40, 32'h0, 32'h0, 0, 8, 0));
        cyc(0, 0, 0, 0, mk(32'h44, w(16), 32'h44, 1, 9, 0));

        if (al) begin
            r = mk(32'h44, 32'h0, 32'h0, 0, 9, 1);
            cyc(0, 0, 1, 32'h66, r);
            cyc(0, 0, 0, 0, r);
            cyc(0, 0, 1, 32'h80, r);
            cyc(1, 0, 0, 0, r);
        end else begin
            cyc(0, 0, 1, 32'h66, mk(32'h64, 32'h0, 32'h0, 0, 9, 0));
            cyc(0, 0, 0, 0, mk(32'h68, 32'h0022_1820, 32'h68, 1, 10, 0));
            cyc(0, 0, 1, 32'h80, mk(32'h80, 32'h0, 32'h0, 0, 10, 0));
            cyc(1, 0, 0, 0, mk(32'h80, 32'h0, 32'h0, 0, 10, 0));
        end

        // Async reset between edges while stalled with a redirect pending.
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        #2;
        reset_now();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, mk(32'h64, 32'h0, 32'h0, 0, 0, 0));
        cyc(0, 0, 0, 0, mk(32'h68, 32'h0022_1820, 32'h68, 1, 1, 0));
        cyc(0, 0, 0, 0, mk(32'h6C, w(26), 32'h6C, 1, 2, 0));

        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
